// File: rtl/pll_lock_ctrl.sv
// PLL supervisor: sequences PLL power-down, reset and lock acquisition, filters
// loss of lock while running, and reports ready/fail to downstream reset logic.
module pll_lock_ctrl #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned RESET_CYCLES       = 64,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned LOSS_FILTER        = 4,
  parameter int unsigned MAX_RETRIES        = 7
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       lock_i,
  input  logic       pwd_req_i,
  input  logic       relock_req_i,
  output logic       pll_reset_o,
  output logic       pll_pwd_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [2:0] state_o,
  output logic [7:0] relock_cnt_o
);

  typedef enum logic [2:0] {
    ST_PWD    = 3'd0,
    ST_RST    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STABLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  localparam int unsigned MAX_AB  = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned LOSS_W  = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lock_s;
  state_t                 state_r, state_nxt;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt;
  logic [LOSS_W-1:0]      loss_r, loss_nxt;
  logic [RETRY_W-1:0]     retry_r, retry_nxt, retry_inc_s;
  logic [7:0]             relock_r, relock_nxt;
  logic                   restart_s;
  logic                   pll_reset_nxt, pll_pwd_nxt, ready_nxt, fail_nxt;
  logic                   pll_reset_r, pll_pwd_r, ready_r, fail_r;

  assign lock_s      = sync_r[SYNC_STAGES-1];
  assign retry_inc_s = retry_r + RETRY_W'(1);

  // Lock synchroniser: lock_i is asynchronous to clkin
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], lock_i};
    end
  end

  // Next-state, counter and registered-output decode
  always_comb begin
    state_nxt  = state_r;
    retry_nxt  = retry_r;
    loss_nxt   = {LOSS_W{1'b0}};
    relock_nxt = relock_r;
    restart_s  = 1'b0;
    if (pwd_req_i) begin
      state_nxt = ST_PWD;
    end else if (relock_req_i) begin
      state_nxt = ST_RST;
      retry_nxt = {RETRY_W{1'b0}};
      restart_s = 1'b1;
    end else begin
      case (state_r)
        ST_PWD: state_nxt = ST_RST;
        ST_RST: begin
          if (cnt_r == RST_LAST) state_nxt = ST_WAIT;
          else                   state_nxt = ST_RST;
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_nxt = ST_STABLE;
          end else if (cnt_r == TO_LAST) begin
            retry_nxt = retry_inc_s;
            if (retry_inc_s == RETRY_LIMIT) state_nxt = ST_FAIL;
            else                            state_nxt = ST_RST;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_nxt = ST_WAIT;
          end else if (cnt_r == STABLE_LAST) begin
            state_nxt = ST_RUN;
            retry_nxt = {RETRY_W{1'b0}};
          end else begin
            state_nxt = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (lock_s) begin
            state_nxt = ST_RUN;
          end else if (loss_r == LOSS_LAST) begin
            state_nxt = ST_RST;
            if (relock_r != 8'hFF) relock_nxt = relock_r + 8'd1;
            else                   relock_nxt = relock_r;
          end else begin
            state_nxt = ST_RUN;
            loss_nxt  = loss_r + LOSS_W'(1);
          end
        end
        ST_FAIL: state_nxt = ST_FAIL;
        default: state_nxt = ST_RST;
      endcase
    end

    // cnt only matters in timed states; parked at zero elsewhere so it never wraps
    if (restart_s || (state_nxt != state_r) || (state_nxt == ST_PWD) ||
        (state_nxt == ST_RUN) || (state_nxt == ST_FAIL)) begin
      cnt_nxt = {CNT_W{1'b0}};
    end else begin
      cnt_nxt = cnt_r + CNT_W'(1);
    end

    pll_reset_nxt = 1'b0;
    pll_pwd_nxt   = 1'b0;
    ready_nxt     = 1'b0;
    fail_nxt      = 1'b0;
    case (state_nxt)
      ST_PWD:  begin pll_pwd_nxt = 1'b1; pll_reset_nxt = 1'b1; end
      ST_RST:  pll_reset_nxt = 1'b1;
      ST_RUN:  ready_nxt = 1'b1;
      ST_FAIL: begin fail_nxt = 1'b1; pll_reset_nxt = 1'b1; end
      default: pll_reset_nxt = 1'b0;
    endcase
  end

  // State, counters and outputs update on the same edge
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RST;
      cnt_r       <= {CNT_W{1'b0}};
      loss_r      <= {LOSS_W{1'b0}};
      retry_r     <= {RETRY_W{1'b0}};
      relock_r    <= 8'd0;
      pll_reset_r <= 1'b1;
      pll_pwd_r   <= 1'b0;
      ready_r     <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      loss_r      <= loss_nxt;
      retry_r     <= retry_nxt;
      relock_r    <= relock_nxt;
      pll_reset_r <= pll_reset_nxt;
      pll_pwd_r   <= pll_pwd_nxt;
      ready_r     <= ready_nxt;
      fail_r      <= fail_nxt;
    end
  end

  assign pll_reset_o  = pll_reset_r;
  assign pll_pwd_o    = pll_pwd_r;
  assign ready_o      = ready_r;
  assign fail_o       = fail_r;
  assign state_o      = state_r;
  assign relock_cnt_o = relock_r;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: a vector table for power-up, glitch filtering
// and relock, then hand sequences for timeout/fail, STABLE drop, power-down, async reset.
module tb_pll_lock_ctrl;

  logic       clkin = 1'b0;
  logic       rst_n;
  logic       lock_i;
  logic       pwd_req_i;
  logic       relock_req_i;
  logic       pll_reset_o;
  logic       pll_pwd_o;
  logic       ready_o;
  logic       fail_o;
  logic [2:0] state_o;
  logic [7:0] relock_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_ctrl #(
    .SYNC_STAGES(2), .RESET_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT(16), .LOSS_FILTER(3), .MAX_RETRIES(2)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .lock_i(lock_i), .pwd_req_i(pwd_req_i),
    .relock_req_i(relock_req_i), .pll_reset_o(pll_reset_o), .pll_pwd_o(pll_pwd_o),
    .ready_o(ready_o), .fail_o(fail_o), .state_o(state_o), .relock_cnt_o(relock_cnt_o)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic       lock;
    logic [2:0] st;
    logic       rst;
    logic       pd;
    logic       rdy;
    logic       fl;
    logic [7:0] rc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input logic lock, input logic [2:0] st,
                              input logic rdy, input logic [7:0] rc);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.lock = lock;
      v.st   = st;
      v.rst  = (st == 3'd0) || (st == 3'd1) || (st == 3'd5);
      v.pd   = (st == 3'd0);
      v.rdy  = rdy;
      v.fl   = (st == 3'd5);
      v.rc   = rc;
      vecs.push_back(v);
    end
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic step(input logic l, input logic p, input logic r);
    lock_i = l; pwd_req_i = p; relock_req_i = r;
    tick();
    relock_req_i = 1'b0;
  endtask

  task automatic chk_outs(input string name, input int idx, input logic [2:0] st,
                          input logic rst, input logic pd, input logic rdy, input logic fl);
    chk({name, "_state"}, idx, {5'd0, state_o}, {5'd0, st});
    chk({name, "_reset"}, idx, {7'd0, pll_reset_o}, {7'd0, rst});
    chk({name, "_pwd"},   idx, {7'd0, pll_pwd_o}, {7'd0, pd});
    chk({name, "_ready"}, idx, {7'd0, ready_o}, {7'd0, rdy});
    chk({name, "_fail"},  idx, {7'd0, fail_o}, {7'd0, fl});
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int n = 0;
    while (state_o !== target && n < budget) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
    end
    chk(name, n, {5'd0, state_o}, {5'd0, target});
  endtask

  initial begin
    logic [2:0] es;

    // Power-up (edges 1..21), glitch filter (22..31), loss and relock (32..45)
    add(3, 1'b0, 3'd1, 1'b0, 8'd0);
    add(7, 1'b0, 3'd2, 1'b0, 8'd0);
    add(2, 1'b1, 3'd2, 1'b0, 8'd0);
    add(8, 1'b1, 3'd3, 1'b0, 8'd0);
    add(1, 1'b1, 3'd4, 1'b1, 8'd0);
    add(2, 1'b0, 3'd4, 1'b1, 8'd0);
    add(4, 1'b1, 3'd4, 1'b1, 8'd0);
    add(3, 1'b0, 3'd4, 1'b1, 8'd0);
    add(1, 1'b1, 3'd4, 1'b1, 8'd0);
    add(4, 1'b1, 3'd1, 1'b0, 8'd1);
    add(1, 1'b1, 3'd2, 1'b0, 8'd1);
    add(8, 1'b1, 3'd3, 1'b0, 8'd1);
    add(1, 1'b1, 3'd4, 1'b1, 8'd1);

    rst_n = 1'b0; lock_i = 1'b0; pwd_req_i = 1'b0; relock_req_i = 1'b0;
    tick(); tick();
    chk_outs("reset", 0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_rc", 0, relock_cnt_o, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].lock, 1'b0, 1'b0);
      chk_outs("tbl", i + 1, vecs[i].st, vecs[i].rst, vecs[i].pd, vecs[i].rdy, vecs[i].fl);
      chk("tbl_rc", i + 1, relock_cnt_o, vecs[i].rc);
    end

    // Timeout twice with lock low -> FAIL
    step(1'b0, 1'b0, 1'b1);
    chk_outs("to_start", 0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b0, 1'b0);
      es = (i <= 3) ? 3'd1 : (i <= 19) ? 3'd2 : (i <= 23) ? 3'd1 : (i <= 39) ? 3'd2 : 3'd5;
      chk_outs("to", i, es, es != 3'd2, 1'b0, 1'b0, es == 3'd5);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_outs("fail_hold", i, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b1);
    chk_outs("fail_clr", 0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // One timeout (retry=1), lock, drop at STABLE cnt=5, next timeout must reach FAIL
    for (int i = 1; i <= 48; i++) begin
      step((i >= 24 && i <= 29), 1'b0, 1'b0);
      es = (i <= 3) ? 3'd1 : (i <= 19) ? 3'd2 : (i <= 23) ? 3'd1 : (i <= 25) ? 3'd2 :
           (i <= 31) ? 3'd3 : (i <= 47) ? 3'd2 : 3'd5;
      chk_outs("stb_drop", i, es, (es == 3'd1) || (es == 3'd5), 1'b0, 1'b0, es == 3'd5);
    end

    // Relock to RUN, then power-down
    step(1'b1, 1'b0, 1'b1);
    chk_outs("relock", 0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_state(3'd4, 40, "run1");
    chk("run1_ready", 0, {7'd0, ready_o}, 8'd1);
    chk("run1_rc", 0, relock_cnt_o, 8'd1);
    step(1'b1, 1'b1, 1'b0);
    chk_outs("pwd", 0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk_outs("pwd", 1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk_outs("pwd_rel", i, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    chk_outs("pwd_rel", 4, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_state(3'd4, 40, "run2");
    chk("run2_ready", 0, {7'd0, ready_o}, 8'd1);
    step(1'b1, 1'b1, 1'b1);
    chk_outs("pwd_wins", 0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pwd_rc", 0, relock_cnt_o, 8'd1);
    step(1'b1, 1'b0, 1'b0);
    chk_outs("pwd_exit", 0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Async reset while in STABLE: outputs must change before any clkin edge
    wait_state(3'd3, 40, "stable");
    step(1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async", 0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("async_rc", 0, relock_cnt_o, 8'd0);
    tick();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    chk_outs("after_rst", 0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
